// File: rtl/alu_pkg.sv
// Shared opcode encodings, divider state type and small helpers for the RV32 ALU.
package alu_pkg;

  localparam logic [4:0] ALU_AND     = 5'd0;
  localparam logic [4:0] ALU_OR      = 5'd1;
  localparam logic [4:0] ALU_ADD     = 5'd2;
  localparam logic [4:0] ALU_XOR     = 5'd3;
  localparam logic [4:0] ALU_SUB     = 5'd4;
  localparam logic [4:0] ALU_NOT     = 5'd5;
  localparam logic [4:0] ALU_SLL     = 5'd6;
  localparam logic [4:0] ALU_SRL     = 5'd7;
  localparam logic [4:0] ALU_SRA     = 5'd8;
  localparam logic [4:0] ALU_SLT     = 5'd9;
  localparam logic [4:0] ALU_SLTU    = 5'd10;
  localparam logic [4:0] ALU_MUL     = 5'd11;
  localparam logic [4:0] ALU_MULH    = 5'd12;
  localparam logic [4:0] ALU_MULHSU  = 5'd13;
  localparam logic [4:0] ALU_MULHU   = 5'd14;
  localparam logic [4:0] ALU_DIV     = 5'd15;
  localparam logic [4:0] ALU_DIVU    = 5'd16;
  localparam logic [4:0] ALU_REM     = 5'd17;
  localparam logic [4:0] ALU_REMU    = 5'd18;
  localparam logic [4:0] ALU_AMOSWAP = 5'd19;
  localparam logic [4:0] ALU_AMOMIN  = 5'd20;
  localparam logic [4:0] ALU_AMOMAX  = 5'd21;
  localparam logic [4:0] ALU_AMOMINU = 5'd22;
  localparam logic [4:0] ALU_AMOMAXU = 5'd23;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock after a load cycle.
module alu_divider
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state_q;
  logic [5:0]  count_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;

  logic [32:0] shifted;
  logic [32:0] trial;

  // Partial remainder stays below the divisor, so the trial difference fits in 32 bits.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
    end else begin
      case (state_q)
        DIV_IDLE, DIV_DONE: begin
          if (start) begin
            state_q <= DIV_BUSY;
            quo_q   <= dividend;
            rem_q   <= '0;
            dvs_q   <= divisor;
            count_q <= 6'(DIV_STEPS);
          end
        end
        DIV_BUSY: begin
          if (!trial[32]) begin
            rem_q <= trial[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= shifted[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end
          count_q <= count_q - 6'd1;
          if (count_q == 6'd1) state_q <= DIV_DONE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == DIV_BUSY);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/rv32_alu.sv
// RV32I/M/A execute-stage ALU: combinational datapath plus a multi-cycle divider
// whose finished result is reused while the operands stay the same.
module rv32_alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  AluControl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        negative,
  output logic        borrow,
  output logic        stall_pipeline
);

  logic        div_op;
  logic        is_signed_div;
  logic        is_rem;
  logic        div_by_zero;
  logic        div_ovf;
  logic        special_case;
  logic        hit;
  logic        pending;
  logic        start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] div_result;

  logic [31:0] a_lat;
  logic [31:0] b_lat;
  logic        signed_lat;

  logic [32:0] sub_ext;
  logic [31:0] sra_res;
  logic        slt;
  logic        sltu;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [31:0] alu_res;

  assign div_op        = (AluControl == ALU_DIV) || (AluControl == ALU_DIVU) ||
                         (AluControl == ALU_REM) || (AluControl == ALU_REMU);
  assign is_signed_div = (AluControl == ALU_DIV) || (AluControl == ALU_REM);
  assign is_rem        = (AluControl == ALU_REM) || (AluControl == ALU_REMU);
  assign div_by_zero   = (b == 32'd0);
  assign div_ovf       = is_signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign special_case  = div_by_zero || div_ovf;

  // A finished division is reusable only if it was computed for these exact operands.
  assign hit     = div_done && (a_lat == a) && (b_lat == b) && (signed_lat == is_signed_div);
  assign pending = div_op && !hit && !special_case;
  assign start   = rst && pending && !div_busy;

  assign stall_pipeline = rst && pending;

  assign div_dividend = is_signed_div ? abs32(a) : a;
  assign div_divisor  = is_signed_div ? abs32(b) : b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_lat      <= '0;
      b_lat      <= '0;
      signed_lat <= 1'b0;
    end else if (start) begin
      a_lat      <= a;
      b_lat      <= b;
      signed_lat <= is_signed_div;
    end
  end

  alu_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Magnitudes come back from the divider; quotient sign is a^b, remainder sign follows a.
  assign quo_fix = (is_signed_div && (a[31] ^ b[31])) ? neg32(div_quotient) : div_quotient;
  assign rem_fix = (is_signed_div && a[31]) ? neg32(div_remainder) : div_remainder;

  always_comb begin
    div_result = '0;
    if (!rst) begin
      div_result = '0;
    end else if (div_by_zero) begin
      div_result = is_rem ? a : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      div_result = is_rem ? 32'd0 : 32'h8000_0000;
    end else if (hit) begin
      div_result = is_rem ? rem_fix : quo_fix;
    end
  end

  assign sub_ext = {1'b0, a} - {1'b0, b};
  assign sra_res = $signed(a) >>> b[4:0];
  assign slt     = $signed(a) < $signed(b);
  assign sltu    = a < b;

  // One 64-bit multiplier serves all four products; only the operand extension differs.
  assign mul_a   = {{32{a[31] && ((AluControl == ALU_MULH) || (AluControl == ALU_MULHSU))}}, a};
  assign mul_b   = {{32{b[31] && (AluControl == ALU_MULH)}}, b};
  assign product = mul_a * mul_b;

  always_comb begin
    alu_res = '0;
    case (AluControl)
      ALU_AND:     alu_res = a & b;
      ALU_OR:      alu_res = a | b;
      ALU_ADD:     alu_res = a + b;
      ALU_XOR:     alu_res = a ^ b;
      ALU_SUB:     alu_res = sub_ext[31:0];
      ALU_NOT:     alu_res = ~a;
      ALU_SLL:     alu_res = a << b[4:0];
      ALU_SRL:     alu_res = a >> b[4:0];
      ALU_SRA:     alu_res = sra_res;
      ALU_SLT:     alu_res = {31'd0, slt};
      ALU_SLTU:    alu_res = {31'd0, sltu};
      ALU_MUL:     alu_res = product[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:   alu_res = product[63:32];
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU:    alu_res = div_result;
      ALU_AMOSWAP: alu_res = b;
      ALU_AMOMIN:  alu_res = slt ? a : b;
      ALU_AMOMAX:  alu_res = slt ? b : a;
      ALU_AMOMINU: alu_res = sltu ? a : b;
      ALU_AMOMAXU: alu_res = sltu ? b : a;
      default:     alu_res = '0;
    endcase
  end

  assign result   = alu_res;
  assign zero     = (alu_res == 32'd0);
  assign negative = alu_res[31];
  assign borrow   = (AluControl == ALU_SUB) && sub_ext[32];

endmodule

// File: tb/tb_rv32_alu.sv
// Randomised scoreboard bench for rv32_alu against an arithmetic reference model.
module tb_rv32_alu;

  logic        clk;
  logic        rst;
  logic [4:0]  alu_control;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        borrow;
  logic        stall_pipeline;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        br;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_item;
  int   stall_cnt;
  int   total;
  int   bad;

  logic        cache_valid;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic        cache_signed;

  rv32_alu dut (
    .clk            (clk),
    .rst            (rst),
    .AluControl     (alu_control),
    .a              (a),
    .b              (b),
    .result         (result),
    .zero           (zero),
    .negative       (negative),
    .borrow         (borrow),
    .stall_pipeline (stall_pipeline)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
    int          sx;
    int          sy;
    longint      ps;
    longint      phs;
    logic [63:0] pu;
    logic [31:0] r;
    sx  = x;
    sy  = y;
    ps  = longint'(sx) * longint'(sy);
    phs = longint'(sx) * longint'({32'd0, y});
    pu  = 64'(x) * 64'(y);
    r   = 32'd0;
    case (op)
      5'd0:  r = x & y;
      5'd1:  r = x | y;
      5'd2:  r = x + y;
      5'd3:  r = x ^ y;
      5'd4:  r = x - y;
      5'd5:  r = ~x;
      5'd6:  r = x << y[4:0];
      5'd7:  r = x >> y[4:0];
      5'd8:  r = sx >>> y[4:0];
      5'd9:  r = (sx < sy) ? 32'd1 : 32'd0;
      5'd10: r = (x < y) ? 32'd1 : 32'd0;
      5'd11: r = ps[31:0];
      5'd12: r = ps[63:32];
      5'd13: r = phs[63:32];
      5'd14: r = pu[63:32];
      5'd15: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = sx / sy;
      end
      5'd16: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd17: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
        else r = sx % sy;
      end
      5'd18: r = (y == 0) ? x : x % y;
      5'd19: r = y;
      5'd20: r = (sx < sy) ? x : y;
      5'd21: r = (sx < sy) ? y : x;
      5'd22: r = (x < y) ? x : y;
      5'd23: r = (x < y) ? y : x;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Predicts result, flags and stall length, queues them, then waits for the monitor to drain.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic is_div;
    logic sgn;
    logic special;
    @(posedge clk);
    #1;
    alu_control = op;
    a = x;
    b = y;
    is_div  = (op >= 5'd15) && (op <= 5'd18);
    sgn     = (op == 5'd15) || (op == 5'd17);
    special = (y == 0) || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    e.op     = op;
    e.res    = ref_result(op, x, y);
    e.z      = (e.res == 0);
    e.n      = e.res[31];
    e.br     = (op == 5'd4) && (x < y);
    e.stalls = 0;
    if (is_div && !special) begin
      if (!(cache_valid && cache_a == x && cache_b == y && cache_signed == sgn)) e.stalls = 33;
      cache_valid  = 1'b1;
      cache_a      = x;
      cache_b      = y;
      cache_signed = sgn;
    end
    exp_q.push_back(e);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL op%0d timeout: output never became valid, stall still %0b",
               op, stall_pipeline);
      exp_q.delete();
    end
  endtask

  // Monitor: counts stalled edges and scores the DUT whenever it presents a valid result.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      if (stall_pipeline) begin
        stall_cnt++;
      end else begin
        mon_item = exp_q.pop_front();
        checkOutput($sformatf("op%0d result", mon_item.op), result, mon_item.res);
        checkOutput($sformatf("op%0d zero", mon_item.op), {31'd0, zero}, {31'd0, mon_item.z});
        checkOutput($sformatf("op%0d negative", mon_item.op), {31'd0, negative}, {31'd0, mon_item.n});
        checkOutput($sformatf("op%0d borrow", mon_item.op), {31'd0, borrow}, {31'd0, mon_item.br});
        checkOutput($sformatf("op%0d stall_edges", mon_item.op), 32'(stall_cnt), 32'(mon_item.stalls));
        stall_cnt = 0;
      end
    end
  end

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          mode;
    total        = 0;
    bad          = 0;
    stall_cnt    = 0;
    cache_valid  = 1'b0;
    cache_a      = '0;
    cache_b      = '0;
    cache_signed = 1'b0;
    rst          = 1'b0;
    alu_control  = 5'd15;
    a            = 32'd13;
    b            = 32'd3;

    // Reset state: divider silent, ordinary ops still live.
    #2;
    checkOutput("reset stall", {31'd0, stall_pipeline}, 32'd0);
    checkOutput("reset div result", result, 32'd0);
    alu_control = 5'd0;
    a = 32'hC;
    b = 32'hA;
    #1;
    checkOutput("reset AND result", result, 32'h8);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    applyStimulus(5'd0,  32'hC, 32'hA);
    applyStimulus(5'd2,  32'd6, 32'd13);
    applyStimulus(5'd4,  32'd5, 32'd6);
    applyStimulus(5'd3,  32'hC, 32'hA);
    applyStimulus(5'd6,  32'h8000_0005, 32'd1);
    applyStimulus(5'd7,  32'hC000_0005, 32'd1);
    applyStimulus(5'd8,  32'hC000_0005, 32'd1);
    applyStimulus(5'd9,  32'hE000_0006, 32'd5);
    applyStimulus(5'd10, 32'hE000_0006, 32'd5);
    applyStimulus(5'd11, 32'hFFFF_FFF4, 32'd10);
    applyStimulus(5'd12, 32'hFFFF_FFF4, 32'd10);
    applyStimulus(5'd13, 32'hFFFF_FFF4, 32'd10);
    applyStimulus(5'd14, 32'hFFFF_FFF4, 32'd10);
    applyStimulus(5'd15, 32'd13, 32'd3);
    applyStimulus(5'd17, 32'd13, 32'd3);
    applyStimulus(5'd15, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(5'd17, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(5'd16, 32'd5, 32'd0);
    applyStimulus(5'd15, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(5'd17, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(5'd18, 32'd5, 32'd0);
    applyStimulus(5'd20, 32'hC000_0005, 32'd1);
    applyStimulus(5'd23, 32'hE000_0006, 32'd5);
    applyStimulus(5'd19, 32'd5, 32'd9);
    applyStimulus(5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Abort a division with reset at its tenth edge, then rerun it in full.
    @(posedge clk);
    #1;
    alu_control = 5'd16;
    a = 32'd100;
    b = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("stall before abort", {31'd0, stall_pipeline}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("stall at abort", {31'd0, stall_pipeline}, 32'd0);
    checkOutput("div result in reset", result, 32'd0);
    cache_valid = 1'b0;
    @(posedge clk);
    #1;
    alu_control = 5'd0;
    rst = 1'b1;
    applyStimulus(5'd16, 32'd100, 32'd7);
    applyStimulus(5'd18, 32'd100, 32'd7);

    for (int i = 0; i < 160; i++) begin
      rop  = 5'($urandom_range(0, 31));
      mode = $urandom_range(0, 7);
      if (mode != 3) begin
        ra = $urandom;
        rb = $urandom;
      end
      case (mode)
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 40));
        2: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        default: ;
      endcase
      applyStimulus(rop, ra, rb);
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
